array_2r1w: RTL

ARRAY_2R1W -- requirements
Module: array_2r1w

---
 rtl/array_2r1w.sv | 132 +++++++++++++
 1 files changed

// File: rtl/array_2r1w.sv
// Two-read, one-write register array with byte-masked writes, write-first reads and
// a self-clearing init sequence that zeroes one row per cycle after reset.
module array_2r1w #(
    parameter int unsigned width_p  = 32,
    parameter int unsigned height_p = 32,
    localparam int unsigned idx_w   = $clog2(height_p),
    localparam int unsigned mask_w  = width_p / 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic               w_v_i,
    input  logic [idx_w-1:0]   w_index_i,
    input  logic [mask_w-1:0]  w_mask_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic               r0_v_i,
    input  logic [idx_w-1:0]   r0_index_i,
    input  logic               r1_v_i,
    input  logic [idx_w-1:0]   r1_index_i,
    output logic [width_p-1:0] r0_data_o,
    output logic [width_p-1:0] r1_data_o,
    output logic               r0_v_o,
    output logic               r1_v_o
);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    localparam logic [idx_w:0]   rows_c     = (idx_w + 1)'(height_p);
    localparam logic [idx_w-1:0] last_row_c = idx_w'(height_p - 1);

    state_e             state_q;
    logic [idx_w-1:0]   clr_ptr_q;
    logic               ready_q;
    logic [width_p-1:0] mem_q [height_p];

    logic               w_fire, r0_fire, r1_fire;
    logic [width_p-1:0] w_row, r0_next, r1_next;
    logic [width_p-1:0] r0_data_q, r1_data_q;
    logic               r0_v_q, r1_v_q;

    function automatic logic [width_p-1:0] merge_bytes(input logic [width_p-1:0] old_row,
                                                       input logic [width_p-1:0] new_row,
                                                       input logic [mask_w-1:0]  mask);
        logic [width_p-1:0] res;
        res = old_row;
        for (int k = 0; k < int'(mask_w); k++) begin
            if (mask[k]) res[8*k +: 8] = new_row[8*k +: 8];
        end
        return res;
    endfunction

    assign w_fire  = ready_q && !reset_i && w_v_i && ({1'b0, w_index_i} < rows_c);
    assign r0_fire = ready_q && !reset_i && r0_v_i;
    assign r1_fire = ready_q && !reset_i && r1_v_i;

    always_comb begin
        w_row = '0;
        if ({1'b0, w_index_i} < rows_c) w_row = merge_bytes(mem_q[w_index_i], w_data_i, w_mask_i);
    end

    // Write-first: a same-row write this cycle is forwarded into the read result.
    always_comb begin
        r0_next = '0;
        if ({1'b0, r0_index_i} < rows_c) begin
            r0_next = (w_fire && (w_index_i == r0_index_i)) ? w_row : mem_q[r0_index_i];
        end
    end

    always_comb begin
        r1_next = '0;
        if ({1'b0, r1_index_i} < rows_c) begin
            r1_next = (w_fire && (w_index_i == r1_index_i)) ? w_row : mem_q[r1_index_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StInit;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (clr_ptr_q == last_row_c) begin
                        state_q   <= StReady;
                        ready_q   <= 1'b1;
                        clr_ptr_q <= '0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                StReady: begin
                    state_q <= StReady;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state_q == StInit) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (w_fire) begin
                mem_q[w_index_i] <= w_row;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r0_v_q    <= 1'b0;
            r1_v_q    <= 1'b0;
            r0_data_q <= '0;
            r1_data_q <= '0;
        end else begin
            r0_v_q <= r0_fire;
            r1_v_q <= r1_fire;
            if (r0_fire) r0_data_q <= r0_next;
            if (r1_fire) r1_data_q <= r1_next;
        end
    end

    assign ready_o   = ready_q;
    assign r0_v_o    = r0_v_q;
    assign r1_v_o    = r1_v_q;
    assign r0_data_o = r0_data_q;
    assign r1_data_o = r1_data_q;

endmodule
